// File: rtl/punt_pkg.sv
// Shared types and constants for the CD32 riser punt/intercept controller.
// The optional timeout feature is selected with the PUNT_TIMEOUT_EN macro.
package punt_pkg;

    // Cycle-level sequencing states for one intercepted 68020 bus cycle
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_TERM    = 2'd2,
        ST_WAIT_AS = 2'd3
    } punt_state_t;

    // DSACK encodings: both high = driven but not terminating, 10 = 8-bit port ack
    localparam logic [1:0] DSACK_IDLE = 2'b11;
    localparam logic [1:0] DSACK_BYTE = 2'b10;

    // Default number of CPU clocks an MCU request may stay outstanding
    localparam int TIMEOUT_CYC_DEF = 200;

    // Isolate the lowest set bit of a request vector (lowest index wins)
    function automatic logic [7:0] lowest_one(input logic [7:0] vec);
        return vec & (~vec + 8'd1);
    endfunction

endpackage

// File: rtl/punt_ack_sync.sv
// Synchroniser for the asynchronous MCU acknowledge, followed by a registered
// rising-edge detector that emits a single-cycle ACK_EDGE pulse.
module punt_ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLKCPU_A,
    input  logic RESET,
    input  logic ACK_IN,
    output logic ACK_EDGE
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   last_reg;
    logic                   edge_reg;

    // First flop samples the raw asynchronous input
    always_ff @(posedge CLKCPU_A or posedge RESET) begin
        if (RESET) begin
            sync_reg[0] <= 1'b0;
        end else begin
            sync_reg[0] <= ACK_IN;
        end
    end

    // Remaining synchroniser stages resolve metastability
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge CLKCPU_A or posedge RESET) begin
                if (RESET) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    // Registered rising-edge detect on the synchronised level
    always_ff @(posedge CLKCPU_A or posedge RESET) begin
        if (RESET) begin
            last_reg <= 1'b0;
            edge_reg <= 1'b0;
        end else begin
            last_reg <= sync_reg[SYNC_STAGES-1];
            edge_reg <= sync_reg[SYNC_STAGES-1] & ~last_reg;
        end
    end

    assign ACK_EDGE = edge_reg;

endmodule

// File: rtl/punt_intercept_ctrl.sv
// Programmable-window address punt controller for the CD32 riser.
// A hit punts the motherboard cycle, raises a one-hot request to the MCU,
// waits for the synchronised acknowledge and terminates the 68020 cycle
// with an 8-bit DSACK. Define PUNT_TIMEOUT_EN to enable the request timeout.
module punt_intercept_ctrl
    import punt_pkg::*;
#(
    parameter int NUM_WIN     = 4,
    parameter int ADDR_W      = 24,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                      CLKCPU_A,
    input  logic                      RESET,
    input  logic                      AS20,
    input  logic                      RW,
    input  logic [ADDR_W-1:0]         A,
    input  logic                      PUNT_IN,
    output logic                      PUNT_OUT,
    input  logic                      ENABLE,
    input  logic [NUM_WIN*ADDR_W-1:0] WIN_BASE,
    input  logic [NUM_WIN*ADDR_W-1:0] WIN_MASK,
    input  logic [NUM_WIN-1:0]        WIN_GATED,
    output logic [NUM_WIN-1:0]        REQ,
    output logic                      REQ_RW,
    input  logic                      ACK_IN,
    output logic [1:0]                DSACK,
    output logic                      TMO
);

    // Reject unusable configurations at elaboration time
    generate
        if (NUM_WIN < 1 || NUM_WIN > 8) begin : g_bad_num_win
            $error("punt_intercept_ctrl: NUM_WIN must be 1..8");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("punt_intercept_ctrl: SYNC_STAGES must be at least 2");
        end
        if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TIMEOUT_W)) begin : g_bad_tmo
            $error("punt_intercept_ctrl: TIMEOUT_CYC must fit in TIMEOUT_W bits");
        end
    endgenerate

    logic [NUM_WIN-1:0] hit_vec;
    logic [NUM_WIN-1:0] win_onehot;
    logic [7:0]         hit_wide;
    logic [7:0]         win_wide;
    logic               any_hit;
    logic               ack_edge;

    punt_state_t        state_reg;
    logic [NUM_WIN-1:0] req_reg;
    logic               req_rw_reg;

    // Per-window decode: masked compare plus optional MCU enable gating
    generate
        for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
            assign hit_vec[gi] =
                (((A ^ WIN_BASE[gi*ADDR_W +: ADDR_W]) & WIN_MASK[gi*ADDR_W +: ADDR_W]) == '0)
                && (!WIN_GATED[gi] || ENABLE);
        end
    endgenerate

    // Priority encode: keep only the lowest-index hit as the request one-hot
    always_comb begin
        hit_wide                = 8'd0;
        hit_wide[NUM_WIN-1:0]   = hit_vec;
        win_wide                = lowest_one(hit_wide);
        win_onehot              = win_wide[NUM_WIN-1:0];
    end

    assign any_hit = |hit_vec;

    // Accelerator punt always wins; otherwise punt only on a window hit
    assign PUNT_OUT = (!PUNT_IN || any_hit) ? 1'b0 : 1'bz;

    punt_ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .CLKCPU_A (CLKCPU_A),
        .RESET    (RESET),
        .ACK_IN   (ACK_IN),
        .ACK_EDGE (ack_edge)
    );

`ifdef PUNT_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_W-1:0] tmo_cnt_reg;
    logic                 tmo_reg;

    // Cycle sequencer with request timeout
    always_ff @(posedge CLKCPU_A or posedge RESET) begin
        if (RESET) begin
            state_reg   <= ST_IDLE;
            req_reg     <= '0;
            req_rw_reg  <= 1'b0;
            tmo_cnt_reg <= '0;
            tmo_reg     <= 1'b0;
        end else begin
            tmo_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!AS20 && PUNT_IN && any_hit) begin
                        state_reg   <= ST_REQ;
                        req_reg     <= win_onehot;
                        req_rw_reg  <= RW;
                        tmo_cnt_reg <= '0;
                    end
                end
                ST_REQ: begin
                    if (AS20) begin
                        state_reg <= ST_IDLE;
                        req_reg   <= '0;
                    end else if (ack_edge) begin
                        state_reg <= ST_TERM;
                        req_reg   <= '0;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        state_reg <= ST_TERM;
                        req_reg   <= '0;
                        tmo_reg   <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_TERM: begin
                    state_reg <= AS20 ? ST_IDLE : ST_WAIT_AS;
                end
                ST_WAIT_AS: begin
                    if (AS20) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_reg   <= '0;
                end
            endcase
        end
    end

    assign TMO = tmo_reg;
`else
    // Cycle sequencer; a request waits for the acknowledge or AS20 negation
    always_ff @(posedge CLKCPU_A or posedge RESET) begin
        if (RESET) begin
            state_reg  <= ST_IDLE;
            req_reg    <= '0;
            req_rw_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!AS20 && PUNT_IN && any_hit) begin
                        state_reg  <= ST_REQ;
                        req_reg    <= win_onehot;
                        req_rw_reg <= RW;
                    end
                end
                ST_REQ: begin
                    if (AS20) begin
                        state_reg <= ST_IDLE;
                        req_reg   <= '0;
                    end else if (ack_edge) begin
                        state_reg <= ST_TERM;
                        req_reg   <= '0;
                    end
                end
                ST_TERM: begin
                    state_reg <= AS20 ? ST_IDLE : ST_WAIT_AS;
                end
                ST_WAIT_AS: begin
                    if (AS20) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_reg   <= '0;
                end
            endcase
        end
    end

    assign TMO = 1'b0;
`endif

    assign REQ    = req_reg;
    assign REQ_RW = req_rw_reg;

    // DSACK: released in IDLE, forced inactive while AS20 is high,
    // otherwise byte-ack once the cycle is being terminated
    assign DSACK = (state_reg == ST_IDLE) ? 2'bzz :
                   AS20                   ? DSACK_IDLE :
                   ((state_reg == ST_TERM) || (state_reg == ST_WAIT_AS)) ? DSACK_BYTE :
                                            DSACK_IDLE;

endmodule

// File: tb/tb_punt_intercept_ctrl.sv
// Directed bench for punt_intercept_ctrl. Released tri-state outputs are
// observed through weak pulls: PUNT_OUT floats to 1, DSACK floats to 2'b00.
module tb_punt_intercept_ctrl;

    localparam int NW  = 4;
    localparam int AW  = 24;
    localparam int SS  = 2;
    localparam logic [1:0] DS_Z    = 2'b00;
    localparam logic [1:0] DS_IDLE = 2'b11;
    localparam logic [1:0] DS_BYTE = 2'b10;

    logic            clk_cpu = 1'b0;
    logic            rst;
    logic            as20;
    logic            rw;
    logic [AW-1:0]   addr;
    logic            punt_in;
    tri1             punt_out_w;
    logic            enable;
    logic [NW*AW-1:0] win_base;
    logic [NW*AW-1:0] win_mask;
    logic [NW-1:0]   win_gated;
    logic [NW-1:0]   req;
    logic            req_rw;
    logic            ack_in;
    tri0  [1:0]      dsack_w;
    logic            tmo;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit req3_seen = 1'b0;

    always #5 clk_cpu = ~clk_cpu;

    punt_intercept_ctrl #(
        .NUM_WIN     (NW),
        .ADDR_W      (AW),
        .SYNC_STAGES (SS),
        .TIMEOUT_W   (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .CLKCPU_A  (clk_cpu),
        .RESET     (rst),
        .AS20      (as20),
        .RW        (rw),
        .A         (addr),
        .PUNT_IN   (punt_in),
        .PUNT_OUT  (punt_out_w),
        .ENABLE    (enable),
        .WIN_BASE  (win_base),
        .WIN_MASK  (win_mask),
        .WIN_GATED (win_gated),
        .REQ       (req),
        .REQ_RW    (req_rw),
        .ACK_IN    (ack_in),
        .DSACK     (dsack_w),
        .TMO       (tmo)
    );

    // Window 3 must never be granted while it shares a hit with window 1
    always @(negedge clk_cpu) begin
        if (req[3]) req3_seen = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_cpu);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst       = 1'b1;
        as20      = 1'b1;
        rw        = 1'b1;
        addr      = 24'h000000;
        punt_in   = 1'b1;
        enable    = 1'b0;
        ack_in    = 1'b0;
        win_gated = 4'b0100;
        win_base[0*AW +: AW] = 24'hDC0000;  win_mask[0*AW +: AW] = 24'hFF0000;
        win_base[1*AW +: AW] = 24'hB80000;  win_mask[1*AW +: AW] = 24'hFF0000;
        win_base[2*AW +: AW] = 24'hDA0000;  win_mask[2*AW +: AW] = 24'hFFF000;
        win_base[3*AW +: AW] = 24'hB80000;  win_mask[3*AW +: AW] = 24'hF00000;

        // Reset state
        tick(2);
        check("rst_req",    {4'd0, req},     8'h00);
        check("rst_req_rw", {7'd0, req_rw},  8'h00);
        check("rst_tmo",    {7'd0, tmo},     8'h00);
        check("rst_dsack",  {6'd0, dsack_w}, {6'd0, DS_Z});
        check("rst_punt",   {7'd0, punt_out_w}, 8'h01);
        rst = 1'b0;
        tick(1);

        // Window 0 read, ACK rises five cycles after the request
        addr = 24'hDC0010; rw = 1'b1; as20 = 1'b0;
        #1;
        check("w0_punt_out", {7'd0, punt_out_w}, 8'h00);
        tick(1);
        check("w0_req",    {4'd0, req},     8'h01);
        check("w0_req_rw", {7'd0, req_rw},  8'h01);
        check("w0_dsack_req", {6'd0, dsack_w}, {6'd0, DS_IDLE});
        tick(5);
        ack_in = 1'b1;
        tick(SS + 1);
        check("w0_dsack_early", {6'd0, dsack_w}, {6'd0, DS_IDLE});
        check("w0_req_held",    {4'd0, req},     8'h01);
        tick(1);
        check("w0_dsack_ack", {6'd0, dsack_w}, {6'd0, DS_BYTE});
        check("w0_req_clr",   {4'd0, req},     8'h00);
        tick(1);
        check("w0_dsack_wait", {6'd0, dsack_w}, {6'd0, DS_BYTE});
        as20 = 1'b1;
        #1;
        check("w0_dsack_force", {6'd0, dsack_w}, {6'd0, DS_IDLE});
        tick(1);
        check("w0_dsack_rel", {6'd0, dsack_w}, {6'd0, DS_Z});
        ack_in = 1'b0;
        tick(4);

        // Windows 1 and 3 overlap: lowest index wins
        addr = 24'hB80100; rw = 1'b0; as20 = 1'b0;
        tick(1);
        check("prio_req",    {4'd0, req},    8'h02);
        check("prio_req_rw", {7'd0, req_rw}, 8'h00);
        ack_in = 1'b1;
        tick(SS + 2);
        check("prio_dsack", {6'd0, dsack_w}, {6'd0, DS_BYTE});
        as20 = 1'b1;
        tick(1);
        ack_in = 1'b0;
        tick(4);
        check("prio_no_w3", {7'd0, req3_seen}, 8'h00);

        // Gated window 2 with ENABLE low, then high
        addr = 24'hDA0004; rw = 1'b1; enable = 1'b0; as20 = 1'b0;
        #1;
        check("gate_punt_off", {7'd0, punt_out_w}, 8'h01);
        tick(3);
        check("gate_req_off",   {4'd0, req},     8'h00);
        check("gate_dsack_off", {6'd0, dsack_w}, {6'd0, DS_Z});
        as20 = 1'b1;
        tick(1);
        enable = 1'b1;
        as20 = 1'b0;
        #1;
        check("gate_punt_on", {7'd0, punt_out_w}, 8'h00);
        tick(1);
        check("gate_req_on", {4'd0, req}, 8'h04);
        as20 = 1'b1;
        #1;
        check("gate_dsack_force", {6'd0, dsack_w}, {6'd0, DS_IDLE});
        tick(1);
        check("gate_dsack_rel", {6'd0, dsack_w}, {6'd0, DS_Z});
        enable = 1'b0;

        // Accelerator owns the cycle: no request, DSACK never driven
        addr = 24'hDC0010; punt_in = 1'b0; as20 = 1'b0;
        #1;
        check("acc_punt", {7'd0, punt_out_w}, 8'h00);
        tick(3);
        check("acc_req",   {4'd0, req},     8'h00);
        check("acc_dsack", {6'd0, dsack_w}, {6'd0, DS_Z});
        as20 = 1'b1; punt_in = 1'b1;
        tick(1);

        // No acknowledge: timeout behaviour depends on the build
        addr = 24'hDC0010; as20 = 1'b0;
        tick(1);
        check("tmo_req", {4'd0, req}, 8'h01);
        tick(15);
        check("tmo_pre", {7'd0, tmo}, 8'h00);
        tick(1);
`ifdef PUNT_TIMEOUT_EN
        check("tmo_pulse", {7'd0, tmo},     8'h01);
        check("tmo_dsack", {6'd0, dsack_w}, {6'd0, DS_BYTE});
        check("tmo_req_clr", {4'd0, req},   8'h00);
        tick(1);
        check("tmo_once",  {7'd0, tmo},     8'h00);
        check("tmo_dsack_hold", {6'd0, dsack_w}, {6'd0, DS_BYTE});
`else
        check("tmo_none",  {7'd0, tmo},     8'h00);
        check("tmo_req_hold", {4'd0, req},  8'h01);
        check("tmo_dsack_req", {6'd0, dsack_w}, {6'd0, DS_IDLE});
        tick(1);
        check("tmo_none2", {7'd0, tmo},     8'h00);
`endif
        as20 = 1'b1;
        tick(1);
        check("tmo_rel", {6'd0, dsack_w}, {6'd0, DS_Z});

        // AS20 negated mid-request, then a stray acknowledge
        as20 = 1'b0;
        tick(1);
        check("abort_req", {4'd0, req}, 8'h01);
        tick(2);
        as20 = 1'b1;
        #1;
        check("abort_force", {6'd0, dsack_w}, {6'd0, DS_IDLE});
        tick(1);
        check("abort_rel",   {6'd0, dsack_w}, {6'd0, DS_Z});
        check("abort_req_clr", {4'd0, req},   8'h00);
        check("abort_tmo",   {7'd0, tmo},     8'h00);
        ack_in = 1'b1;
        tick(2);
        ack_in = 1'b0;
        tick(5);
        check("stray_ack_dsack", {6'd0, dsack_w}, {6'd0, DS_Z});
        check("stray_ack_req",   {4'd0, req},     8'h00);

        // Reset asserted in the middle of a request
        rw = 1'b1; as20 = 1'b0;
        tick(1);
        check("mid_req", {4'd0, req}, 8'h01);
        check("mid_dsack", {6'd0, dsack_w}, {6'd0, DS_IDLE});
        rst = 1'b1;
        #1;
        check("mid_rst_req",   {4'd0, req},     8'h00);
        check("mid_rst_rw",    {7'd0, req_rw},  8'h00);
        check("mid_rst_dsack", {6'd0, dsack_w}, {6'd0, DS_Z});
        check("mid_rst_tmo",   {7'd0, tmo},     8'h00);
        as20 = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/punt_intercept_ctrl.md
Name: punt_intercept_ctrl

Overview:
- Parametrised successor to the CD32 riser address-punt logic: NUM_WIN runtime-programmable decode windows replace the fixed RTC/JOY/POT/CIA decodes.
- On a hit, the block punts the motherboard cycle and raises a per-window request to the MCU over SPI-side signals.
- It waits for a synchronised MCU acknowledge, then terminates the 68020 cycle with DSACK.
- It adds cycle-level sequencing, priority, abort on AS20 negation, and an optional timeout.

Parameters:
- NUM_WIN, 4, number of decode windows (1..8).
- ADDR_W, 24, CPU address width.
- SYNC_STAGES, 2, synchroniser depth on ACK_IN (>=2).
- TIMEOUT_W, 8, timeout counter width.
- TIMEOUT_CYC, 200, CLKCPU_A cycles in REQ before forced termination (< 2**TIMEOUT_W).

Ports:
- CLKCPU_A  in  1  CPU clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- AS20  in  1  CPU address strobe, active low.
- RW  in  1  CPU read/write.
- A  in  ADDR_W  CPU address.
- PUNT_IN  in  1  accelerator punt; low = accelerator owns the cycle.
- PUNT_OUT  out  1  punt to motherboard: 0 / z.
- ENABLE  in  1  MCU enable for gated windows.
- WIN_BASE  in  NUM_WIN*ADDR_W  window i base at [i*ADDR_W +: ADDR_W].
- WIN_MASK  in  NUM_WIN*ADDR_W  1 = address bit compared.
- WIN_GATED  in  NUM_WIN  1 = window active only when ENABLE=1.
- REQ  out  NUM_WIN  one-hot request to MCU.
- REQ_RW  out  1  latched RW of the active request.
- ACK_IN  in  1  asynchronous MCU acknowledge.
- DSACK  out  2  cycle termination: 2'b10 / 2'b11 / zz.
- TMO  out  1  one-cycle pulse on timeout.

Behaviour:
- Hit decode:
  - hit[i] = ((A ^ WIN_BASE_i) & WIN_MASK_i) == 0, AND (!WIN_GATED[i] | ENABLE).
  - Combinational; lowest index wins when several windows hit.
- PUNT_OUT = !PUNT_IN ? 0 : (any_hit ? 0 : z). Purely combinational, so the accelerator punt has priority.
- ACK_IN passes through a SYNC_STAGES flop chain, then a rising-edge detector giving ack_edge.
- States: IDLE, REQ, TERM, WAIT_AS.
- IDLE:
  - Go to REQ when AS20=0, PUNT_IN=1 and any_hit are all sampled at an edge.
  - On that edge: latch winner index, set REQ[idx]=1, latch REQ_RW=RW, clear the timeout counter.
- REQ:
  - ack_edge → TERM, REQ cleared.
  - Timeout: counter reaches TIMEOUT_CYC-1 → TERM, REQ cleared, TMO=1 for one cycle.
  - ack_edge and timeout on the same edge: ack wins, no TMO.
- TERM: DSACK=2'b10 (8-bit port ack); next edge → WAIT_AS.
- WAIT_AS: DSACK holds 2'b10 until AS20 is sampled high, then → IDLE.
- AS20 negation in any non-IDLE state:
  - Next edge → IDLE, REQ cleared, no TMO.
  - DSACK is forced to 2'b11 asynchronously while AS20=1.
- DSACK drive: driven (2'b11 or 2'b10) only when state != IDLE, otherwise zz. Never driven if PUNT_IN=0 at the request edge, because no request is taken.
- An ack_edge outside REQ is ignored.
- A new cycle cannot start until the state returns to IDLE.
- Reset values: state IDLE, REQ=0, REQ_RW=0, TMO=0, counter 0, sync chain 0, DSACK=zz.
- Reset mid-cycle releases DSACK immediately.
- Latency, ACK_IN rise to DSACK low: SYNC_STAGES+2 edges.

Optional Feature:
- PUNT_TIMEOUT_EN defined:
  - Counter, timeout transition and TMO are present as described.
- PUNT_TIMEOUT_EN undefined:
  - REQ waits indefinitely for ack_edge or AS20 negation.
  - TMO tied 0; TIMEOUT_W/TIMEOUT_CYC unused.

Decomposition:
- Package punt_pkg:
  - State enum (IDLE, REQ, TERM, WAIT_AS).
  - DSACK_IDLE=2'b11, DSACK_BYTE=2'b10.
  - Default TIMEOUT_CYC.
- Sub-module punt_ack_sync: SYNC_STAGES synchroniser plus rising-edge pulse, with RESET.
- Priority encoder stays inline.

Test Plan:
- Window 0 base 24'hDC0000, mask 24'hFF0000; read A=24'hDC0010, PUNT_IN=1, ACK_IN rises 5 cycles later:
  - REQ=4'b0001 one edge after AS20 low.
  - DSACK=2'b10 SYNC_STAGES+2 edges after the ACK rise.
  - DSACK=zz one edge after AS20 high.
- Windows 1 and 3 both hit:
  - REQ=4'b0010; window 3 never asserted.
- Gated window 2, ENABLE=0, address hits:
  - PUNT_OUT=z, REQ=0, DSACK=zz.
  - With ENABLE=1: PUNT_OUT=0, REQ=4'b0100.
- PUNT_IN=0 with hit address:
  - PUNT_OUT=0, REQ stays 0, DSACK=zz throughout.
- PUNT_TIMEOUT_EN, TIMEOUT_CYC=16, no ACK:
  - TMO pulses exactly once, 16 edges after REQ rises.
  - DSACK=2'b10 next edge; REQ cleared.
- AS20 negated while in REQ:
  - DSACK=2'b11 immediately, IDLE next edge, TMO=0.
  - A later ACK_IN pulse produces no DSACK.
  - RESET asserted mid-REQ: all outputs return to reset values immediately.
